arb_req_client4: RTL and testbench
==================================

ARB_REQ_CLIENT4 -- requirements
Module: arb_req_client4

Interface
REQ-001 SHALL have parameter BURST_LEN, default 4, beats issued per granted job (range 1..15).
REQ-002 SHALL have parameter CNT_W, default 3, width of each channel's pending-job counter.
REQ-003 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port push  input  4  per-channel job enqueue strobe, bit0=channel 1.
REQ-006 SHALL have port gnt_vld  input  1  arbiter grant valid this cycle.
REQ-007 SHALL have port gnt_idx  input  2  granted channel index, 2'b00=channel 1 .. 2'b11=channel 4.
REQ-008 SHALL have port sig1..sig4  output  1 each  request lines to the 4-to-1 arbiter.
REQ-009 SHALL have port ena  output  1  arbiter enable; high only while client can accept a grant.
REQ-010 SHALL have port beat_vld  output  1  one transfer beat of the granted job this cycle.
REQ-011 SHALL have port beat_ch  output  2  channel index owning the current beat.
REQ-012 SHALL have port done  output  4  one-cycle pulse per channel on job completion.
REQ-013 SHALL have port ovf  output  4  sticky per-channel overflow flag.
REQ-014 SHALL have port gnt_err  output  1  one-cycle pulse on grant to a non-requesting channel.

Function
REQ-015 SHALL keep four CNT_W-bit pending counters; push[i] increments counter i.
REQ-016 SHALL drop push[i] when counter i is at 2^CNT_W-1 (no wrap) and set ovf[i]; ovf clears only on reset.
REQ-017 SHALL drive sig(i+1) = (counter i != 0) AND NOT (state!=IDLE AND owner==i), registered.
REQ-018 SHALL implement FSM IDLE, BURST, GAP.
REQ-019 IDLE: ena=1; on gnt_vld with sig[gnt_idx]=1 latch owner=gnt_idx, clear beat counter, go BURST next cycle.
REQ-020 IDLE: gnt_vld with sig[gnt_idx]=0 SHALL pulse gnt_err next cycle and stay IDLE.
REQ-021 BURST: ena=0, beat_vld=1, beat_ch=owner each cycle; after exactly BURST_LEN beats go GAP.
REQ-022 On last beat SHALL decrement owner's counter and pulse done[owner] the following cycle (first GAP cycle).
REQ-023 GAP: one cycle, ena=0, beat_vld=0, owner request held low; then IDLE.
REQ-024 Grant-to-first-beat latency SHALL be 1 cycle; grant-to-next-ena SHALL be BURST_LEN+2 cycles.
REQ-025 push[owner] coinciding with the decrement SHALL leave the counter unchanged (net zero).
REQ-026 gnt_vld outside IDLE SHALL be ignored without gnt_err.
REQ-027 beat_ch SHALL read 2'b00 when beat_vld=0.

Reset
REQ-028 rst_n low SHALL asynchronously force: state IDLE, counters 0, sig1..sig4 0, ena 1, beat_vld 0, beat_ch 0, done 0, ovf 0, gnt_err 0.
REQ-029 Reset mid-BURST SHALL abort the job with no done pulse; pending count lost.

Structure
REQ-030 Shared package SHALL hold FSM state encoding (IDLE/BURST/GAP) and 2-bit channel index constants CH1..CH4 matching arbiter S1..S4.
REQ-031 SHALL use one sub-module, arb_pend_cnt, instantiated 4 times (saturating up/down counter with ovf).

Verification
REQ-032 push=4'b0010 once, gnt_vld=1 gnt_idx=2'b01 next cycle -> beat_vld 4 cycles beat_ch=01, done=4'b0010, sig2 low afterwards.
REQ-033 push[0] 8 times with CNT_W=3 -> counter 7, ovf[0]=1 on 8th, sig1 high.
REQ-034 gnt_vld=1 gnt_idx=2'b11 with no pending -> gnt_err pulse, no beats, state IDLE.
REQ-035 counter[2]=2, push[2] on last beat -> counter stays 2, done[2] pulse, sig3 re-asserts after GAP.
REQ-036 rst_n low on 2nd beat -> all outputs reset values immediately, no done pulse, ena=1.
REQ-037 gnt_vld pulsed during BURST -> ignored, no gnt_err, owner unchanged.

Source files
------------

// File: rtl/arb_req_client4_pkg.sv
// -----------------------------------------------------------------------------
// arb_req_client4_pkg
// Shared definitions for the 4-channel arbiter request client:
//   - state_t   : client FSM encoding (IDLE / BURST / GAP)
//   - CH1..CH4  : 2-bit channel indices, identical to the arbiter's S1..S4
//   - NUM_CH    : number of client channels
//   - BEAT_W    : width of the beat counter (covers BURST_LEN up to 15)
// -----------------------------------------------------------------------------
package arb_req_client4_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam int CH_W   = 2;
    localparam int NUM_CH = 4;
    localparam int BEAT_W = 4;

    localparam logic [CH_W-1:0] CH1 = 2'b00;
    localparam logic [CH_W-1:0] CH2 = 2'b01;
    localparam logic [CH_W-1:0] CH3 = 2'b10;
    localparam logic [CH_W-1:0] CH4 = 2'b11;

endpackage : arb_req_client4_pkg

// File: rtl/arb_pend_cnt.sv
// -----------------------------------------------------------------------------
// arb_pend_cnt
// Pending-job counter for one client channel. Saturating up/down counter:
// an increment at full scale is dropped and raises a sticky overflow flag;
// simultaneous increment and decrement cancel out.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   i_inc      in   enqueue one job
//   i_dec      in   retire one job
//   o_cnt_next out  value the counter takes at the next clock edge
//   o_ovf      out  sticky overflow flag, cleared only by reset
// -----------------------------------------------------------------------------
module arb_pend_cnt
    import arb_req_client4_pkg::*;
#(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_inc,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_cnt_next,
    output logic             o_ovf
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;
    logic             w_full;
    logic             w_empty;
    logic             w_drop;

    assign w_full  = (r_cnt == CNT_MAX);
    assign w_empty = (r_cnt == '0);
    assign w_drop  = i_inc && !i_dec && w_full;

    // NOTE: every combinational output gets a default before any branch so
    // no path leaves it unassigned, which would infer a latch.
    always_comb begin
        o_cnt_next = r_cnt;
        if (i_inc && !i_dec && !w_full) begin
            o_cnt_next = r_cnt + 1'b1;
        end else if (i_dec && !i_inc && !w_empty) begin
            o_cnt_next = r_cnt - 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values; all of them, counter included, are reset
    // asynchronously so a mid-job reset drops pending work immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else begin
            r_cnt <= o_cnt_next;
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign o_ovf = r_ovf;

endmodule : arb_pend_cnt

// File: rtl/arb_req_client4.sv
// -----------------------------------------------------------------------------
// arb_req_client4
// Four-channel client of a 4-to-1 arbiter. Each channel queues jobs in a
// pending counter and requests the arbiter while work is pending. A granted
// job is issued as BURST_LEN consecutive beats, followed by one GAP cycle in
// which the job is retired and its done pulse is visible.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   push[3:0]  in   per-channel enqueue strobe, bit0 = channel 1
//   gnt_vld    in   arbiter grant valid
//   gnt_idx    in   granted channel, 2'b00 = channel 1
//   sig1..sig4 out  registered request lines to the arbiter
//   ena        out  arbiter enable, high only while idle
//   beat_vld   out  one transfer beat this cycle
//   beat_ch    out  channel owning the beat (0 when no beat)
//   done[3:0]  out  one-cycle job completion pulse per channel
//   ovf[3:0]   out  sticky per-channel pending-counter overflow
//   gnt_err    out  one-cycle pulse on a grant to a non-requesting channel
// -----------------------------------------------------------------------------
module arb_req_client4
    import arb_req_client4_pkg::*;
#(
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] push,
    input  logic              gnt_vld,
    input  logic [CH_W-1:0]   gnt_idx,
    output logic              sig1,
    output logic              sig2,
    output logic              sig3,
    output logic              sig4,
    output logic              ena,
    output logic              beat_vld,
    output logic [CH_W-1:0]   beat_ch,
    output logic [NUM_CH-1:0] done,
    output logic [NUM_CH-1:0] ovf,
    output logic              gnt_err
);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic [CH_W-1:0]     r_owner;
    logic [CH_W-1:0]     w_owner_next;
    logic [BEAT_W-1:0]   r_beat_cnt;
    logic [BEAT_W-1:0]   w_beat_cnt_next;
    logic [NUM_CH-1:0]   r_sig;
    logic [NUM_CH-1:0]   w_sig_next;
    logic [NUM_CH-1:0]   r_done;
    logic [NUM_CH-1:0]   w_done_next;
    logic                r_gnt_err;
    logic                w_gnt_err_next;
    logic [NUM_CH-1:0]   w_dec;
    logic [CNT_W-1:0]    w_cnt_next [NUM_CH];

    // ------------------------------------------------------------------
    // Pending-job counters, one per channel
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt
        arb_pend_cnt #(
            .CNT_W (CNT_W)
        ) u_pend_cnt (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_inc      (push[g]),
            .i_dec      (w_dec[g]),
            .o_cnt_next (w_cnt_next[g]),
            .o_ovf      (ovf[g])
        );
    end

    // ------------------------------------------------------------------
    // FSM next-state and Moore outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next    = r_state;
        w_owner_next    = r_owner;
        w_beat_cnt_next = r_beat_cnt;
        w_gnt_err_next  = 1'b0;
        w_done_next     = '0;
        w_dec           = '0;
        ena             = 1'b0;
        beat_vld        = 1'b0;
        beat_ch         = CH1;

        case (r_state)
            IDLE: begin
                ena = 1'b1;
                if (gnt_vld) begin
                    // Grants are judged against the request line the arbiter
                    // actually saw, not the raw pending count.
                    if (r_sig[gnt_idx]) begin
                        w_owner_next    = gnt_idx;
                        w_beat_cnt_next = '0;
                        w_state_next    = BURST;
                    end else begin
                        w_gnt_err_next = 1'b1;
                    end
                end
            end

            BURST: begin
                beat_vld = 1'b1;
                beat_ch  = r_owner;
                if (r_beat_cnt == LAST_BEAT) begin
                    // Retire on the last beat so the count is already
                    // correct when done is seen in GAP.
                    w_dec[r_owner]       = 1'b1;
                    w_done_next[r_owner] = 1'b1;
                    w_state_next         = GAP;
                end else begin
                    w_beat_cnt_next = r_beat_cnt + 1'b1;
                end
            end

            GAP: begin
                w_state_next = IDLE;
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Request lines are computed from next-cycle values so a push is visible
    // to the arbiter one edge later, and the owner's line drops on the same
    // edge that starts its burst.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_sig_next[i] = (w_cnt_next[i] != '0) &&
                            !((w_state_next != IDLE) && (w_owner_next == CH_W'(i)));
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_owner    <= CH1;
            r_beat_cnt <= '0;
            r_sig      <= '0;
            r_done     <= '0;
            r_gnt_err  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_owner    <= w_owner_next;
            r_beat_cnt <= w_beat_cnt_next;
            r_sig      <= w_sig_next;
            r_done     <= w_done_next;
            r_gnt_err  <= w_gnt_err_next;
        end
    end

    assign sig1    = r_sig[0];
    assign sig2    = r_sig[1];
    assign sig3    = r_sig[2];
    assign sig4    = r_sig[3];
    assign done    = r_done;
    assign gnt_err = r_gnt_err;

endmodule : arb_req_client4

// File: tb/tb_arb_req_client4.sv
// -----------------------------------------------------------------------------
// tb_arb_req_client4
// Directed testbench for arb_req_client4 (BURST_LEN=4, CNT_W=3). Inputs are
// driven 1 ns after the rising edge; outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_arb_req_client4;

    localparam int BURST_LEN = 4;
    localparam int CNT_W     = 3;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic [3:0] push    = 4'b0000;
    logic       gnt_vld = 1'b0;
    logic [1:0] gnt_idx = 2'b00;

    logic       sig1, sig2, sig3, sig4;
    logic       ena;
    logic       beat_vld;
    logic [1:0] beat_ch;
    logic [3:0] done;
    logic [3:0] ovf;
    logic       gnt_err;

    logic [3:0]  sig;
    logic [16:0] obs;
    assign sig = {sig4, sig3, sig2, sig1};
    assign obs = {sig, ena, beat_vld, beat_ch, done, ovf, gnt_err};

    // {sig, ena, beat_vld, beat_ch, done, ovf, gnt_err} after reset
    localparam logic [16:0] RESET_OBS = {4'b0000, 1'b1, 1'b0, 2'b00, 4'b0000, 4'b0000, 1'b0};

    int n_checks = 0;
    int n_fail   = 0;

    arb_req_client4 #(
        .BURST_LEN (BURST_LEN),
        .CNT_W     (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .gnt_vld  (gnt_vld),
        .gnt_idx  (gnt_idx),
        .sig1     (sig1),
        .sig2     (sig2),
        .sig3     (sig3),
        .sig4     (sig4),
        .ena      (ena),
        .beat_vld (beat_vld),
        .beat_ch  (beat_ch),
        .done     (done),
        .ovf      (ovf),
        .gnt_err  (gnt_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Grant a channel and wait until the client is back in IDLE.
    task automatic grant_and_wait(input logic [1:0] ch);
        gnt_idx = ch;
        gnt_vld = 1'b1;
        cycle();
        gnt_vld = 1'b0;
        repeat (BURST_LEN + 1) cycle();
    endtask

    task automatic test_reset();
        #12;
        n_checks++;
        if (obs !== RESET_OBS) begin
            n_fail++;
            $display("FAIL reset_in: got %h expected %h", obs, RESET_OBS);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle();
        n_checks++;
        if (obs !== RESET_OBS) begin
            n_fail++;
            $display("FAIL reset_out: got %h expected %h", obs, RESET_OBS);
        end
    endtask

    task automatic test_single_job();
        push = 4'b0010;
        cycle();
        push = 4'b0000;
        n_checks++;
        if (sig !== 4'b0010) begin
            n_fail++;
            $display("FAIL single_req: sig got %b expected 0010", sig);
        end
        gnt_idx = 2'b01;
        gnt_vld = 1'b1;
        cycle();
        gnt_vld = 1'b0;
        for (int b = 0; b < BURST_LEN; b++) begin
            n_checks++;
            if ({ena, beat_vld, beat_ch, sig, done} !== {1'b0, 1'b1, 2'b01, 4'b0000, 4'b0000}) begin
                n_fail++;
                $display("FAIL single_beat%0d: {ena,vld,ch,sig,done} got %b expected 0101_0000_0000",
                         b, {ena, beat_vld, beat_ch, sig, done});
            end
            cycle();
        end
        n_checks++;
        if ({ena, beat_vld, beat_ch, sig, done} !== {1'b0, 1'b0, 2'b00, 4'b0000, 4'b0010}) begin
            n_fail++;
            $display("FAIL single_gap: {ena,vld,ch,sig,done} got %b expected 0000_0000_0010",
                     {ena, beat_vld, beat_ch, sig, done});
        end
        cycle();
        n_checks++;
        if ({ena, beat_vld, sig, done} !== {1'b1, 1'b0, 4'b0000, 4'b0000}) begin
            n_fail++;
            $display("FAIL single_idle: {ena,vld,sig,done} got %b expected 10_0000_0000",
                     {ena, beat_vld, sig, done});
        end
    endtask

    task automatic test_overflow();
        push = 4'b0001;
        for (int k = 1; k <= 8; k++) begin
            cycle();
            if (k == 7) begin
                n_checks++;
                if (ovf !== 4'b0000) begin
                    n_fail++;
                    $display("FAIL ovf_early: ovf got %b expected 0000", ovf);
                end
            end
        end
        push = 4'b0000;
        n_checks++;
        if ({sig, ovf} !== {4'b0001, 4'b0001}) begin
            n_fail++;
            $display("FAIL ovf_set: {sig,ovf} got %b expected 0001_0001", {sig, ovf});
        end
        // Seven jobs must drain the saturated counter exactly.
        for (int j = 1; j <= 7; j++) begin
            grant_and_wait(2'b00);
            n_checks++;
            if ({ena, sig, ovf} !== {1'b1, (j < 7) ? 4'b0001 : 4'b0000, 4'b0001}) begin
                n_fail++;
                $display("FAIL ovf_drain%0d: {ena,sig,ovf} got %b expected %b",
                         j, {ena, sig, ovf}, {1'b1, (j < 7) ? 4'b0001 : 4'b0000, 4'b0001});
            end
        end
    endtask

    task automatic test_gnt_err();
        gnt_idx = 2'b11;
        gnt_vld = 1'b1;
        cycle();
        gnt_vld = 1'b0;
        n_checks++;
        if ({gnt_err, beat_vld, ena} !== 3'b101) begin
            n_fail++;
            $display("FAIL gnt_err_pulse: {err,vld,ena} got %b expected 101", {gnt_err, beat_vld, ena});
        end
        cycle();
        n_checks++;
        if ({gnt_err, beat_vld, ena} !== 3'b001) begin
            n_fail++;
            $display("FAIL gnt_err_clear: {err,vld,ena} got %b expected 001", {gnt_err, beat_vld, ena});
        end
    endtask

    task automatic test_push_on_last_beat();
        push = 4'b0100;
        cycle();
        cycle();
        push = 4'b0000;
        gnt_idx = 2'b10;
        gnt_vld = 1'b1;
        cycle();
        gnt_vld = 1'b0;
        for (int b = 0; b < BURST_LEN; b++) begin
            n_checks++;
            if ({beat_vld, beat_ch, sig[2]} !== {1'b1, 2'b10, 1'b0}) begin
                n_fail++;
                $display("FAIL last_beat%0d: {vld,ch,sig3} got %b expected 1100", b, {beat_vld, beat_ch, sig[2]});
            end
            if (b == BURST_LEN - 1) push = 4'b0100;
            cycle();
            push = 4'b0000;
        end
        n_checks++;
        if ({done, sig} !== {4'b0100, 4'b0000}) begin
            n_fail++;
            $display("FAIL last_gap: {done,sig} got %b expected 0100_0000", {done, sig});
        end
        cycle();
        n_checks++;
        if ({done, sig, ena} !== {4'b0000, 4'b0100, 1'b1}) begin
            n_fail++;
            $display("FAIL last_idle: {done,sig,ena} got %b expected 0000_0100_1", {done, sig, ena});
        end
        // Counter must still hold 2: two more jobs, request drops after the second.
        grant_and_wait(2'b10);
        n_checks++;
        if (sig !== 4'b0100) begin
            n_fail++;
            $display("FAIL last_drain1: sig got %b expected 0100", sig);
        end
        grant_and_wait(2'b10);
        n_checks++;
        if (sig !== 4'b0000) begin
            n_fail++;
            $display("FAIL last_drain2: sig got %b expected 0000", sig);
        end
    endtask

    task automatic test_gnt_during_burst();
        push = 4'b0101;
        cycle();
        push = 4'b0000;
        gnt_idx = 2'b00;
        gnt_vld = 1'b1;
        cycle();
        gnt_vld = 1'b0;
        for (int b = 0; b < BURST_LEN; b++) begin
            n_checks++;
            if ({beat_vld, beat_ch, gnt_err} !== {1'b1, 2'b00, 1'b0}) begin
                n_fail++;
                $display("FAIL busy_beat%0d: {vld,ch,err} got %b expected 1000", b, {beat_vld, beat_ch, gnt_err});
            end
            if (b == 1) begin
                gnt_idx = 2'b10;
                gnt_vld = 1'b1;
            end
            cycle();
            gnt_vld = 1'b0;
        end
        n_checks++;
        if ({done, gnt_err, beat_vld} !== {4'b0001, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL busy_gap: {done,err,vld} got %b expected 0001_00", {done, gnt_err, beat_vld});
        end
        cycle();
        n_checks++;
        if ({sig, gnt_err, ena, beat_vld} !== {4'b0100, 1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL busy_idle: {sig,err,ena,vld} got %b expected 0100_010", {sig, gnt_err, ena, beat_vld});
        end
        grant_and_wait(2'b10);
        n_checks++;
        if (sig !== 4'b0000) begin
            n_fail++;
            $display("FAIL busy_drain: sig got %b expected 0000", sig);
        end
    endtask

    task automatic test_reset_mid_burst();
        push = 4'b1000;
        cycle();
        push = 4'b0000;
        gnt_idx = 2'b11;
        gnt_vld = 1'b1;
        cycle();
        gnt_vld = 1'b0;
        cycle();
        n_checks++;
        if ({beat_vld, beat_ch, ovf} !== {1'b1, 2'b11, 4'b0001}) begin
            n_fail++;
            $display("FAIL rst_pre: {vld,ch,ovf} got %b expected 111_0001", {beat_vld, beat_ch, ovf});
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (obs !== RESET_OBS) begin
            n_fail++;
            $display("FAIL rst_async: got %h expected %h", obs, RESET_OBS);
        end
        for (int k = 0; k < 3; k++) begin
            cycle();
            n_checks++;
            if (obs !== RESET_OBS) begin
                n_fail++;
                $display("FAIL rst_hold%0d: got %h expected %h", k, obs, RESET_OBS);
            end
        end
        rst_n = 1'b1;
        cycle();
        cycle();
        n_checks++;
        if (obs !== RESET_OBS) begin
            n_fail++;
            $display("FAIL rst_after: got %h expected %h", obs, RESET_OBS);
        end
    endtask

    initial begin
        test_reset();
        test_single_job();
        test_overflow();
        test_gnt_err();
        test_push_on_last_beat();
        test_gnt_during_burst();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_arb_req_client4
